// File: rtl/mcsr_unit.sv
// Machine-mode CSR file: mstatus/mie/mip/trap CSRs, read-only ID registers,
// and cycle/instret/hpm counters with inhibit control.
module mcsr_unit #(
   parameter int unsigned NUM_HPM     = 4,
   parameter int unsigned COUNTER_W   = 64,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [11:0]                              csr_addr_i,
   input  logic [1:0]                               csr_op_i,
   input  logic [31:0]                              csr_wdata_i,
   output logic [31:0]                              csr_rdata_o,
   output logic                                     csr_illegal_o,
   input  logic [31:0]                              mhartid_i,
   input  logic                                     irq_ext_i,
   input  logic                                     irq_timer_i,
   input  logic                                     irq_sw_i,
   input  logic                                     trap_i,
   input  logic [31:0]                              trap_pc_i,
   input  logic [31:0]                              trap_cause_i,
   input  logic [31:0]                              trap_val_i,
   input  logic                                     mret_i,
   input  logic                                     instret_i,
   input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event_i,
   output logic                                     irq_pending_o,
   output logic [31:0]                              mtvec_o,
   output logic [31:0]                              mepc_o
);

   localparam int unsigned HPM_N     = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [1:0]  OP_NONE   = 2'b00;
   localparam logic [1:0]  OP_RW     = 2'b01;
   localparam logic [1:0]  OP_RS     = 2'b10;
   localparam logic [31:0] IRQ_MASK  = 32'h0000_0888;
   localparam logic [31:0] MISA_VAL  = 32'h4010_0104;
   localparam logic [31:0] CINH_MASK = 32'((64'd1 << (NUM_HPM + 3)) - 64'd8) | 32'h0000_0005;

   logic                 r_st_mie, r_st_mpie;
   logic [31:0]          r_mie, r_mip, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mcinh;
   logic [COUNTER_W-1:0] r_mcycle, r_minstret;
   logic [COUNTER_W-1:0] r_hpm [HPM_N];

   logic        w_impl, w_cnt_acc, w_cnt_hi, w_we, w_cwe;
   logic [4:0]  w_idx;
   logic [31:0] w_rd, w_wv;
   logic [63:0] w_cnt;

   // Replace one 32-bit half of a counter, keeping the other half.
   function automatic logic [COUNTER_W-1:0] f_set_half(input logic [COUNTER_W-1:0] c,
                                                      input logic hi, input logic [31:0] v);
      logic [63:0] t;
      t = 64'(c);
      if (hi) t[63:32] = v;
      else    t[31:0]  = v;
      return t[COUNTER_W-1:0];
   endfunction

   // Address decode and pre-write read value
   always_comb begin
      w_impl    = 1'b1;
      w_rd      = '0;
      w_cnt_acc = 1'b0;
      w_cnt_hi  = csr_addr_i[7];
      w_idx     = csr_addr_i[4:0];
      w_cnt     = '0;
      if (w_idx == 5'd0)      w_cnt = 64'(r_mcycle);
      else if (w_idx == 5'd2) w_cnt = 64'(r_minstret);
      for (int k = 0; k < NUM_HPM; k++)
         if (w_idx == 5'(k + 3)) w_cnt = 64'(r_hpm[k]);
      case (csr_addr_i)
         12'h300: w_rd = {19'd0, 2'b11, 3'd0, r_st_mpie, 3'd0, r_st_mie, 3'd0};
         12'h301: w_rd = MISA_VAL;
         12'h304: w_rd = r_mie;
         12'h305: w_rd = r_mtvec;
         12'h320: w_rd = r_mcinh;
         12'h340: w_rd = r_mscratch;
         12'h341: w_rd = r_mepc;
         12'h342: w_rd = r_mcause;
         12'h343: w_rd = r_mtval;
         12'h344: w_rd = r_mip;
         12'hF11, 12'hF12, 12'hF13: w_rd = '0;
         12'hF14: w_rd = mhartid_i;
         default: begin
            if (csr_addr_i[11:8] == 4'hB && csr_addr_i[6:5] == 2'b00) begin
               w_cnt_acc = 1'b1;
               if (w_idx == 5'd1 || (w_cnt_hi && COUNTER_W == 32)) w_impl = 1'b0;
               else w_rd = w_cnt_hi ? w_cnt[63:32] : w_cnt[31:0];
            end else begin
               w_impl = 1'b0;
            end
         end
      endcase

      csr_illegal_o = (csr_op_i != OP_NONE) &&
                      (!w_impl || (csr_addr_i[11:10] == 2'b11 &&
                                   (csr_op_i == OP_RW || csr_wdata_i != '0)));
      csr_rdata_o = csr_illegal_o ? 32'd0 : w_rd;

      case (csr_op_i)
         OP_RW:   w_wv = csr_wdata_i;
         OP_RS:   w_wv = w_rd | csr_wdata_i;
         2'b11:   w_wv = w_rd & ~csr_wdata_i;
         default: w_wv = w_rd;
      endcase
      w_we  = (csr_op_i != OP_NONE) && !csr_illegal_o;
      w_cwe = w_we && w_cnt_acc;
   end

   // Status/trap CSRs: trap beats mret beats software write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st_mie   <= 1'b0;
         r_st_mpie  <= 1'b0;
         r_mie      <= '0;
         r_mip      <= '0;
         r_mtvec    <= MTVEC_RESET;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
         r_mcinh    <= '0;
      end else begin
         r_mip <= {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_sw_i, 3'd0};
         if (trap_i) begin
            r_st_mpie <= r_st_mie;
            r_st_mie  <= 1'b0;
            r_mepc    <= trap_pc_i & ~32'h1;
            r_mcause  <= trap_cause_i;
            r_mtval   <= trap_val_i;
         end else if (mret_i) begin
            r_st_mie  <= r_st_mpie;
            r_st_mpie <= 1'b1;
         end else if (w_we && csr_addr_i == 12'h300) begin
            r_st_mie  <= w_wv[3];
            r_st_mpie <= w_wv[7];
         end
         if (!trap_i && w_we) begin
            if (csr_addr_i == 12'h341) r_mepc   <= w_wv & ~32'h1;
            if (csr_addr_i == 12'h342) r_mcause <= w_wv;
            if (csr_addr_i == 12'h343) r_mtval  <= w_wv;
         end
         if (w_we) begin
            if (csr_addr_i == 12'h304) r_mie      <= w_wv & IRQ_MASK;
            if (csr_addr_i == 12'h305) r_mtvec    <= w_wv[1] ? {w_wv[31:2], 2'b00} : w_wv;
            if (csr_addr_i == 12'h320) r_mcinh    <= w_wv & CINH_MASK;
            if (csr_addr_i == 12'h340) r_mscratch <= w_wv;
         end
      end
   end

   // Counters: a write to either half replaces it and skips that cycle's increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
         for (int k = 0; k < HPM_N; k++) r_hpm[k] <= '0;
      end else begin
         if (w_cwe && w_idx == 5'd0)  r_mcycle <= f_set_half(r_mcycle, w_cnt_hi, w_wv);
         else if (!r_mcinh[0])        r_mcycle <= r_mcycle + COUNTER_W'(1);
         if (w_cwe && w_idx == 5'd2)  r_minstret <= f_set_half(r_minstret, w_cnt_hi, w_wv);
         else if (!r_mcinh[2])        r_minstret <= r_minstret + COUNTER_W'(instret_i);
         for (int k = 0; k < NUM_HPM; k++) begin
            if (w_cwe && w_idx == 5'(k + 3)) r_hpm[k] <= f_set_half(r_hpm[k], w_cnt_hi, w_wv);
            else if (!r_mcinh[k + 3])        r_hpm[k] <= r_hpm[k] + COUNTER_W'(hpm_event_i[k]);
         end
      end
   end

   assign irq_pending_o = r_st_mie & |(r_mip & r_mie);
   assign mtvec_o       = r_mtvec;
   assign mepc_o        = r_mepc;

endmodule

// File: tb/tb_mcsr_unit.sv
// Bench for mcsr_unit: table of CSR accesses plus hand sequences for traps,
// counters, interrupts and reset; expectations flow through a scoreboard queue.
module tb_mcsr_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata, csr_rdata;
   logic        csr_illegal;
   logic        irq_ext, irq_timer, irq_sw;
   logic        trap, mret, instret;
   logic [31:0] trap_pc, trap_cause, trap_val;
   logic [3:0]  hpm_event;
   logic        irq_pending;
   logic [31:0] mtvec, mepc;

   localparam logic [31:0] HART  = 32'hCAFE_0001;
   localparam logic [31:0] MTVR  = 32'h0000_1000;
   localparam logic [1:0]  NONE  = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

   int total = 0;
   int bad   = 0;

   typedef struct packed { logic [31:0] rd; logic ill; } exp_t;
   exp_t sb[$];

   typedef struct { logic [1:0] op; logic [11:0] addr; logic [31:0] wd; logic [31:0] rd; logic ill; } vec_t;
   vec_t tbl[$];

   mcsr_unit #(.NUM_HPM(4), .COUNTER_W(64), .MTVEC_RESET(MTVR)) dut (
      .clk(clk), .reset(reset),
      .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
      .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
      .mhartid_i(HART),
      .irq_ext_i(irq_ext), .irq_timer_i(irq_timer), .irq_sw_i(irq_sw),
      .trap_i(trap), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .trap_val_i(trap_val),
      .mret_i(mret), .instret_i(instret), .hpm_event_i(hpm_event),
      .irq_pending_o(irq_pending), .mtvec_o(mtvec), .mepc_o(mepc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // One access per cycle: drive after the edge, score at negedge, commit at next edge.
   task automatic acc(input string nm, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic ill);
      exp_t e;
      csr_op = op; csr_addr = a; csr_wdata = wd;
      sb.push_back('{rd: rd, ill: ill});
      @(negedge clk);
      e = sb.pop_front();
      chk({nm, ".rd"}, csr_rdata, e.rd);
      chk({nm, ".ill"}, 32'(csr_illegal), 32'(e.ill));
      @(posedge clk); #1;
      csr_op = NONE;
   endtask

   initial begin
      reset = 1'b0; csr_addr = '0; csr_op = NONE; csr_wdata = '0;
      irq_ext = 0; irq_timer = 0; irq_sw = 0; trap = 0; mret = 0; instret = 0;
      trap_pc = '0; trap_cause = '0; trap_val = '0; hpm_event = '0;

      tbl.push_back('{RW,   12'h320, 32'hFFFF_FFFF, 32'h0,         1'b0});
      tbl.push_back('{NONE, 12'h320, 32'h0,         32'h7D,        1'b0});
      tbl.push_back('{RW,   12'h300, 32'h8,         32'h1800,      1'b0});
      tbl.push_back('{RS,   12'h300, 32'h80,        32'h1808,      1'b0});
      tbl.push_back('{RC,   12'h300, 32'h08,        32'h1888,      1'b0});
      tbl.push_back('{NONE, 12'h300, 32'h0,         32'h1880,      1'b0});
      tbl.push_back('{RW,   12'h305, 32'h2003,      MTVR,          1'b0});
      tbl.push_back('{NONE, 12'h305, 32'h0,         32'h2000,      1'b0});
      tbl.push_back('{RW,   12'h341, 32'h123,       32'h0,         1'b0});
      tbl.push_back('{NONE, 12'h341, 32'h0,         32'h122,       1'b0});
      tbl.push_back('{RW,   12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0});
      tbl.push_back('{NONE, 12'h304, 32'h0,         32'h888,       1'b0});
      tbl.push_back('{RW,   12'h344, 32'hFFFF_FFFF, 32'h0,         1'b0});
      tbl.push_back('{NONE, 12'h344, 32'h0,         32'h0,         1'b0});
      tbl.push_back('{RW,   12'hF14, 32'h1,         32'h0,         1'b1});
      tbl.push_back('{RS,   12'hF14, 32'h0,         HART,          1'b0});
      tbl.push_back('{RC,   12'hF14, 32'h5,         32'h0,         1'b1});
      tbl.push_back('{RW,   12'h7C0, 32'h1,         32'h0,         1'b1});
      tbl.push_back('{NONE, 12'h7C0, 32'h0,         32'h0,         1'b0});
      tbl.push_back('{NONE, 12'h301, 32'h0,         32'h4010_0104, 1'b0});
      tbl.push_back('{RS,   12'hF11, 32'h0,         32'h0,         1'b0});
      tbl.push_back('{RW,   12'hB1F, 32'h55,        32'h0,         1'b0});
      tbl.push_back('{RW,   12'hB9F, 32'h55,        32'h0,         1'b0});
      tbl.push_back('{RW,   12'hB01, 32'h1,         32'h0,         1'b1});
      tbl.push_back('{RW,   12'h340, 32'hDEAD_BEEF, 32'h0,         1'b0});
      tbl.push_back('{RC,   12'h340, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0});
      tbl.push_back('{NONE, 12'h340, 32'h0,         32'h0000_BEEF, 1'b0});
      tbl.push_back('{NONE, 12'hB00, 32'h0,         32'h3,         1'b0});
      tbl.push_back('{RW,   12'hB02, 32'h10,        32'h0,         1'b0});
      tbl.push_back('{NONE, 12'hB02, 32'h0,         32'h10,        1'b0});
      tbl.push_back('{RW,   12'hB80, 32'h0,         32'h0,         1'b0});
      tbl.push_back('{RW,   12'hB00, 32'h5,         32'h3,         1'b0});
      tbl.push_back('{NONE, 12'hB1F, 32'h0,         32'h0,         1'b0});

      // Values held in reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst.mtvec_o", mtvec, MTVR);
      chk("rst.mepc_o", mepc, 32'h0);
      chk("rst.irq_pending", 32'(irq_pending), 32'h0);
      csr_addr = 12'h300; #1 chk("rst.mstatus", csr_rdata, 32'h1800);
      csr_addr = 12'hB00; #1 chk("rst.mcycle", csr_rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Counting starts on the first edge after release
      acc("cyc0", NONE, 12'hB00, 32'h0, 32'h0, 1'b0);
      acc("cyc1", NONE, 12'hB00, 32'h0, 32'h1, 1'b0);

      for (int i = 0; i < tbl.size(); i++)
         acc($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].ill);
      chk("mtvec_o", mtvec, 32'h2000);

      // Counter write suppresses the increment, then carries into the high half
      acc("uninhibit", RW,   12'h320, 32'h0,         32'h7D,        1'b0);
      acc("cyc.wr",    RW,   12'hB00, 32'hFFFF_FFFF, 32'h5,         1'b0);
      acc("cyc.hold",  NONE, 12'hB00, 32'h0,         32'hFFFF_FFFF, 1'b0);
      acc("cyc.wrap",  NONE, 12'hB00, 32'h0,         32'h0,         1'b0);
      acc("cyc.hi",    NONE, 12'hB80, 32'h0,         32'h1,         1'b0);

      instret = 1'b1; hpm_event = 4'b0101;
      acc("ret0", NONE, 12'hB02, 32'h0, 32'h10, 1'b0);
      acc("ret1", NONE, 12'hB02, 32'h0, 32'h11, 1'b0);
      acc("ret2", NONE, 12'hB02, 32'h0, 32'h12, 1'b0);
      instret = 1'b0; hpm_event = 4'b0000;
      acc("ret3", NONE, 12'hB02, 32'h0, 32'h13, 1'b0);
      acc("hpm3", NONE, 12'hB03, 32'h0, 32'h3,  1'b0);
      acc("hpm5", NONE, 12'hB05, 32'h0, 32'h3,  1'b0);
      acc("hpm4", NONE, 12'hB04, 32'h0, 32'h0,  1'b0);

      // Trap with colliding mepc write, then mret with colliding mstatus write
      acc("mie.on", RW, 12'h300, 32'h8, 32'h1880, 1'b0);
      trap = 1'b1; trap_pc = 32'h1003; trap_cause = 32'h8000_000B; trap_val = 32'hBAD;
      acc("trap.wr", RW, 12'h341, 32'h100, 32'h122, 1'b0);
      trap = 1'b0;
      chk("trap.mepc_o", mepc, 32'h1002);
      acc("trap.mcause",  NONE, 12'h342, 32'h0, 32'h8000_000B, 1'b0);
      acc("trap.mtval",   NONE, 12'h343, 32'h0, 32'hBAD,       1'b0);
      acc("trap.mstatus", NONE, 12'h300, 32'h0, 32'h1880,      1'b0);
      mret = 1'b1;
      acc("mret.wr", RW, 12'h300, 32'h0, 32'h1880, 1'b0);
      mret = 1'b0;
      acc("mret.mstatus", NONE, 12'h300, 32'h0, 32'h1888, 1'b0);

      // Trap alongside a write to an untouched CSR
      trap = 1'b1; trap_pc = 32'h2000; trap_cause = 32'h3; trap_val = 32'h0;
      acc("trap2.wr", RW, 12'h340, 32'h55, 32'h0000_BEEF, 1'b0);
      trap = 1'b0;
      acc("trap2.mscratch", NONE, 12'h340, 32'h0, 32'h55,   1'b0);
      acc("trap2.mstatus",  NONE, 12'h300, 32'h0, 32'h1880, 1'b0);
      mret = 1'b1;
      acc("mret2.mepc", NONE, 12'h341, 32'h0, 32'h2000, 1'b0);
      mret = 1'b0;
      acc("mret2.mstatus", NONE, 12'h300, 32'h0, 32'h1888, 1'b0);

      // Timer interrupt: mip follows one edge later, then MIE gates it
      acc("mie.wr", RW, 12'h304, 32'h80, 32'h888, 1'b0);
      irq_timer = 1'b1;
      chk("irq.before", 32'(irq_pending), 32'h0);
      acc("mip.lag", NONE, 12'h344, 32'h0, 32'h0, 1'b0);
      chk("irq.pend", 32'(irq_pending), 32'h1);
      acc("mip.set", NONE, 12'h344, 32'h0, 32'h80, 1'b0);
      acc("mie.clr", RC, 12'h300, 32'h8, 32'h1888, 1'b0);
      chk("irq.gated", 32'(irq_pending), 32'h0);

      // Asynchronous reset mid-cycle aborts a pending write and trap
      csr_op = RW; csr_addr = 12'h340; csr_wdata = 32'h99;
      trap = 1'b1; trap_pc = 32'h3000; trap_cause = 32'h7;
      #2 reset = 1'b0;
      #1;
      chk("arst.mepc_o", mepc, 32'h0);
      chk("arst.mtvec_o", mtvec, MTVR);
      chk("arst.irq", 32'(irq_pending), 32'h0);
      csr_op = NONE; trap = 1'b0;
      csr_addr = 12'hB00; #1 chk("arst.mcycle", csr_rdata, 32'h0);
      csr_addr = 12'hB80; #1 chk("arst.mcycleh", csr_rdata, 32'h0);
      csr_addr = 12'hB02; #1 chk("arst.minstret", csr_rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      acc("post.mscratch", NONE, 12'h340, 32'h0, 32'h0,    1'b0);
      acc("post.mcause",   NONE, 12'h342, 32'h0, 32'h0,    1'b0);
      acc("post.mstatus",  NONE, 12'h300, 32'h0, 32'h1800, 1'b0);
      acc("post.cyc",      NONE, 12'hB02, 32'h0, 32'h0,    1'b0);
      acc("post.cyc2",     NONE, 12'hB00, 32'h0, 32'h4,    1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
